// File: rtl/rx_medida_7e1.sv
// 7E1 UART receiver for the distance meter link: deserializes characters and
// parses "units, tens, hundreds, '#'" frames into a 12-bit BCD measurement.
module rx_medida_7e1 #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] medida,
    output logic        medida_valida,
    output logic        erro_paridade,
    output logic        erro_formato,
    output logic [3:0]  db_estado
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MEIO   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [6:0]    HASH   = 7'h23;

    typedef enum logic [2:0] {
        OCIOSO       = 3'd0,
        START        = 3'd1,
        DADOS        = 3'd2,
        STOP         = 3'd3,
        ESPERA_LINHA = 3'd4
    } rx_t;

    typedef enum logic [2:0] {
        ESPERA_UNIDADE = 3'd0,
        ESPERA_DEZENA  = 3'd1,
        ESPERA_CENTENA = 3'd2,
        ESPERA_HASH    = 3'd3,
        RESSINC        = 3'd4
    } slot_t;

    rx_t   rx_estado, rx_prox;
    slot_t slot, slot_prox;

    logic          sinc1, linha, linha_ant;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic          par_flag;
    logic [6:0]    dados;
    logic          bit_par;
    logic [3:0]    unid, dez, cent;

    logic amostra, fim_char;
    logic eh_hash, eh_digito, par_ok;
    logic guarda, valida_prox, erro_par_prox, erro_fmt_prox;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc1     <= 1'b1;
            linha     <= 1'b1;
            linha_ant <= 1'b1;
        end else begin
            sinc1     <= entrada_serial;
            linha     <= sinc1;
            linha_ant <= linha;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rx_estado <= OCIOSO;
        else        rx_estado <= rx_prox;
    end

    always_comb begin
        rx_prox  = rx_estado;
        amostra  = 1'b0;
        fim_char = 1'b0;
        case (rx_estado)
            OCIOSO: if (linha_ant && !linha) rx_prox = START;
            START: if (cnt == MEIO) begin
                amostra = 1'b1;
                rx_prox = linha ? OCIOSO : DADOS;
            end
            DADOS: if (cnt == ULTIMO) begin
                amostra = 1'b1;
                if (par_flag) rx_prox = STOP;
            end
            STOP: if (cnt == ULTIMO) begin
                amostra  = 1'b1;
                fim_char = 1'b1;
                rx_prox  = linha ? OCIOSO : ESPERA_LINHA;
            end
            ESPERA_LINHA: if (linha) rx_prox = OCIOSO;
            default: rx_prox = OCIOSO;
        endcase
    end

    // Baud counter restarts on every sample so each state times from its own entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            par_flag <= 1'b0;
            dados    <= '0;
            bit_par  <= 1'b0;
        end else begin
            if ((rx_estado == START || rx_estado == DADOS || rx_estado == STOP) && !amostra)
                cnt <= cnt + CW'(1);
            else
                cnt <= '0;

            if (rx_estado == OCIOSO) begin
                bit_cnt  <= '0;
                par_flag <= 1'b0;
            end else if (rx_estado == DADOS && amostra) begin
                if (!par_flag) begin
                    dados <= {linha, dados[6:1]};
                    if (bit_cnt == 3'd6) par_flag <= 1'b1;
                    else                 bit_cnt  <= bit_cnt + 3'd1;
                end else begin
                    bit_par <= linha;
                end
            end
        end
    end

    assign eh_hash   = (dados == HASH);
    assign eh_digito = (dados >= 7'h30) && (dados <= 7'h39);
    assign par_ok    = ((^dados) == bit_par);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) slot <= ESPERA_UNIDADE;
        else        slot <= slot_prox;
    end

    // A bad stop bit outranks a parity error so a character never raises two pulses.
    always_comb begin
        slot_prox     = slot;
        guarda        = 1'b0;
        valida_prox   = 1'b0;
        erro_par_prox = 1'b0;
        erro_fmt_prox = 1'b0;
        if (fim_char) begin
            if (!linha) begin
                erro_fmt_prox = 1'b1;
                slot_prox     = RESSINC;
            end else if (!par_ok) begin
                erro_par_prox = 1'b1;
                slot_prox     = RESSINC;
            end else begin
                case (slot)
                    ESPERA_UNIDADE, ESPERA_DEZENA, ESPERA_CENTENA: begin
                        if (eh_digito) begin
                            guarda = 1'b1;
                            if (slot == ESPERA_UNIDADE)     slot_prox = ESPERA_DEZENA;
                            else if (slot == ESPERA_DEZENA) slot_prox = ESPERA_CENTENA;
                            else                            slot_prox = ESPERA_HASH;
                        end else begin
                            erro_fmt_prox = 1'b1;
                            slot_prox     = eh_hash ? ESPERA_UNIDADE : RESSINC;
                        end
                    end
                    ESPERA_HASH: begin
                        if (eh_hash) begin
                            valida_prox = 1'b1;
                            slot_prox   = ESPERA_UNIDADE;
                        end else begin
                            erro_fmt_prox = 1'b1;
                            slot_prox     = RESSINC;
                        end
                    end
                    RESSINC: if (eh_hash) slot_prox = ESPERA_UNIDADE;
                    default: slot_prox = RESSINC;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            unid          <= '0;
            dez           <= '0;
            cent          <= '0;
            medida        <= '0;
            medida_valida <= 1'b0;
            erro_paridade <= 1'b0;
            erro_formato  <= 1'b0;
        end else begin
            if (guarda) begin
                case (slot)
                    ESPERA_UNIDADE: unid <= dados[3:0];
                    ESPERA_DEZENA:  dez  <= dados[3:0];
                    default:        cent <= dados[3:0];
                endcase
            end
            if (valida_prox) medida <= {cent, dez, unid};
            medida_valida <= valida_prox;
            erro_paridade <= erro_par_prox;
            erro_formato  <= erro_fmt_prox;
        end
    end

    assign db_estado = {rx_estado[1:0], slot[1:0]};

endmodule

// File: tb/tb_rx_medida_7e1.sv
// Self-checking bench for rx_medida_7e1: directed frames plus random frames,
// checked against a queue-based frame model.
module tb_rx_medida_7e1;

    localparam int unsigned CPB = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        entrada_serial;
    logic [11:0] medida;
    logic        medida_valida, erro_paridade, erro_formato;
    logic [3:0]  db_estado;

    int tests = 0, fails = 0;
    int n_val = 0, n_par = 0, n_fmt = 0, n_both = 0;
    int e_val = 0, e_par = 0, e_fmt = 0, e_med = 0;
    logic [3:0] q[$];
    bit ressinc = 1'b0;

    rx_medida_7e1 #(.CLKS_PER_BIT(CPB)) dut (
        .clock(clock),
        .reset(reset),
        .entrada_serial(entrada_serial),
        .medida(medida),
        .medida_valida(medida_valida),
        .erro_paridade(erro_paridade),
        .erro_formato(erro_formato),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (medida_valida === 1'b1) n_val++;
        if (erro_paridade === 1'b1) n_par++;
        if (erro_formato === 1'b1) n_fmt++;
        if (medida_valida === 1'b1 && (erro_paridade === 1'b1 || erro_formato === 1'b1)) n_both++;
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame rules applied to one received character.
    task automatic model_char(input logic [6:0] c, input bit bad_par, input bit bad_stop);
        bit dig;
        dig = (c >= 7'h30) && (c <= 7'h39);
        if (bad_stop) begin
            e_fmt++; ressinc = 1'b1; q.delete();
        end else if (bad_par) begin
            e_par++; ressinc = 1'b1; q.delete();
        end else if (ressinc) begin
            if (c == 7'h23) begin ressinc = 1'b0; q.delete(); end
        end else if (q.size() < 3) begin
            if (dig) q.push_back(c[3:0]);
            else begin
                e_fmt++; q.delete(); ressinc = (c != 7'h23);
            end
        end else begin
            if (c == 7'h23) begin
                e_val++; e_med = q[2] * 256 + q[1] * 16 + q[0];
            end else begin
                e_fmt++; ressinc = 1'b1;
            end
            q.delete();
        end
    endtask

    task automatic check_events(input string tag);
        check({tag, " valid count"}, n_val, e_val);
        check({tag, " parity err count"}, n_par, e_par);
        check({tag, " format err count"}, n_fmt, e_fmt);
        check({tag, " medida"}, int'(medida), e_med);
    endtask

    task automatic drive_bits(input logic [9:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            entrada_serial = fr[i];
            repeat (CPB) @(posedge clock);
            #1;
        end
    endtask

    task automatic send_char(input logic [6:0] c, input bit bad_par, input bit bad_stop, input string tag);
        logic [9:0] fr;
        fr = {~bad_stop, (^c) ^ bad_par, c, 1'b0};
        drive_bits(fr, 10);
        model_char(c, bad_par, bad_stop);
        check_events(tag);
    endtask

    task automatic send_frame(input logic [3:0] u, input logic [3:0] d, input logic [3:0] h, input string tag);
        send_char({3'b011, u}, 1'b0, 1'b0, tag);
        send_char({3'b011, d}, 1'b0, 1'b0, tag);
        send_char({3'b011, h}, 1'b0, 1'b0, tag);
        send_char(7'h23, 1'b0, 1'b0, tag);
    endtask

    task automatic idle(input int n);
        entrada_serial = 1'b1;
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        logic [6:0] c;
        logic [9:0] fr;
        bit bp;
        int r;

        reset = 1'b0;
        entrada_serial = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("reset medida", int'(medida), 0);
        check("reset valid", int'(medida_valida), 0);
        check("reset parity err", int'(erro_paridade), 0);
        check("reset format err", int'(erro_formato), 0);
        check("reset db_estado", int'(db_estado), 0);
        reset = 1'b1;
        idle(10);

        // 1: basic frame
        send_frame(4'd5, 4'd2, 4'd1, "t1");
        check("t1 medida 125", int'(medida), 12'h125);
        idle(12);
        check("t1 db_estado idle", int'(db_estado), 0);

        // 2: back-to-back frames
        send_frame(4'd0, 4'd0, 4'd4, "t2a");
        check("t2 medida 400", int'(medida), 12'h400);
        send_frame(4'd7, 4'd9, 4'd3, "t2b");
        check("t2 medida 397", int'(medida), 12'h397);
        idle(12);

        // 3: parity error discards frame
        send_char(7'h35, 1'b1, 1'b0, "t3 bad parity");
        send_char(7'h32, 1'b0, 1'b0, "t3 discard");
        send_char(7'h31, 1'b0, 1'b0, "t3 discard");
        send_char(7'h23, 1'b0, 1'b0, "t3 resync");
        send_frame(4'd8, 4'd0, 4'd0, "t3b");
        check("t3 medida 008", int'(medida), 12'h008);
        check("t3 parity pulses", n_par, 1);
        idle(12);

        // 4: '#' in digit slot resyncs immediately
        send_char(7'h35, 1'b0, 1'b0, "t4 digit");
        send_char(7'h23, 1'b0, 1'b0, "t4 early hash");
        send_frame(4'd1, 4'd2, 4'd3, "t4b");
        check("t4 medida 321", int'(medida), 12'h321);
        idle(12);

        // 5: glitch, then bad stop bit followed by a break
        entrada_serial = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        idle(20);
        check_events("t5 glitch");
        check("t5 db_estado after glitch", int'(db_estado), 0);
        send_char(7'h37, 1'b0, 1'b1, "t5 bad stop");
        entrada_serial = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        idle(16);
        check_events("t5 break");
        send_char(7'h23, 1'b0, 1'b0, "t5 resync");
        send_frame(4'd4, 4'd5, 4'd6, "t5b");
        check("t5 medida 654", int'(medida), 12'h654);
        idle(12);

        // 6: reset mid-character
        send_char(7'h31, 1'b0, 1'b0, "t6 units");
        fr = {1'b1, ^7'h36, 7'h36, 1'b0};
        drive_bits(fr, 5);
        reset = 1'b0;
        #2;
        check("t6 reset medida", int'(medida), 0);
        check("t6 reset valid", int'(medida_valida), 0);
        check("t6 reset parity err", int'(erro_paridade), 0);
        check("t6 reset format err", int'(erro_formato), 0);
        check("t6 reset db_estado", int'(db_estado), 0);
        entrada_serial = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        q.delete();
        ressinc = 1'b0;
        e_med = 0;
        idle(16);
        send_frame(4'd6, 4'd6, 4'd6, "t6b");
        check("t6 medida 666", int'(medida), 12'h666);
        idle(12);

        // Random frames with occasional corrupted characters
        for (int f = 0; f < 10; f++) begin
            for (int k = 0; k < 4; k++) begin
                c = (k < 3) ? {3'b011, 4'($urandom_range(0, 9))} : 7'h23;
                r = $urandom_range(0, 15);
                if (r == 0) c = 7'(7'h3A + $urandom_range(0, 5));
                else if (r == 1) c = 7'h23;
                else if (r == 2) c = 7'h41;
                bp = ($urandom_range(0, 11) == 0);
                send_char(c, bp, 1'b0, "rand");
            end
            if (ressinc) send_char(7'h23, 1'b0, 1'b0, "rand resync");
            if (q.size() != 0) begin
                send_char(7'h23, 1'b0, 1'b0, "rand flush");
                if (ressinc) send_char(7'h23, 1'b0, 1'b0, "rand resync2");
            end
            idle($urandom_range(0, 20));
        end

        check("exclusive pulses", n_both, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
